// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment frame decoder: segment
// patterns (abcdefg, bit6 = a), BCD codes, FSM states and helpers.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [6:0] SEG_BLANK   = 7'b0000000;
  localparam logic [3:0] BCD_INVALID = 4'hF;
  localparam logic [3:0] BCD_BLANK   = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD,
    PUBLISH
  } state_t;

  // True when exactly one digit enable is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Slot index of a one-hot enable; only meaningful when is_onehot(v).
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[1]) idx = 2'd1;
    if (v[2]) idx = 2'd2;
    if (v[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to BCD decoder.
// With SEG7_BLANK_EN defined, an all-off pattern decodes to BCD_BLANK as a
// valid digit; otherwise it is treated as undecodable.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       valid
);

  // Map a segment pattern to its digit; unknown patterns are flagged invalid.
  always_comb begin
    bcd   = BCD_INVALID;
    valid = 1'b1;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
`ifdef SEG7_BLANK_EN
      SEG_BLANK: bcd = BCD_BLANK;
`endif
      default: begin
        bcd   = BCD_INVALID;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Recovers a four-digit BCD frame from a multiplexed seven-segment display
// bus. Each digit is captured once its pattern and enable have been stable
// for STABLE_CYCLES samples; a frame is published when all four slots hold
// a fresh capture. Optional macro: SEG7_BLANK_EN (see seg7_decode).
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_en,
  output logic [15:0] bcd_out,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

  logic [6:0] seg_s;
  logic [3:0] en_s;
  logic [6:0] seg_p;
  logic [3:0] en_p;

  state_t     state;
  state_t     nxt_state;
  logic [3:0] cnt;
  logic [3:0] nxt_cnt;
  logic       cap;
  logic       pub;

  logic [3:0] slot_bcd [4];
  logic [3:0] invalid;
  logic [3:0] captured;

  logic [3:0] dec_bcd;
  logic       dec_valid;
  logic       same;
  logic       onehot;
  logic [1:0] slot_idx;

  seg7_decode u_decode (
    .seg   (seg_s),
    .bcd   (dec_bcd),
    .valid (dec_valid)
  );

  // Sample the display bus, and keep the previous sample for stability checks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s <= '0;
      en_s  <= '0;
      seg_p <= '0;
      en_p  <= '0;
    end else begin
      seg_s <= seg_in;
      en_s  <= dig_en;
      seg_p <= seg_s;
      en_p  <= en_s;
    end
  end

  // Per-sample qualifiers used by the next-state logic.
  always_comb begin
    same     = (seg_s == seg_p) && (en_s == en_p);
    onehot   = is_onehot(en_s);
    slot_idx = onehot_idx(en_s);
  end

  // Next-state decision. Capture is folded into the transition that makes the
  // counter reach STABLE_CNT, so STABLE_CYCLES = 1 captures on the first
  // one-hot sample straight out of IDLE or HOLD.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    cap       = 1'b0;
    pub       = 1'b0;
    case (state)
      IDLE: begin
        if (onehot) begin
          nxt_state = SETTLE;
          nxt_cnt   = 4'd1;
        end
      end
      SETTLE: begin
        if (same) begin
          nxt_cnt = cnt + 4'd1;
        end else if (onehot) begin
          nxt_cnt = 4'd1;
        end else begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      end
      HOLD: begin
        if (en_s != en_p) begin
          if (onehot) begin
            nxt_state = SETTLE;
            nxt_cnt   = 4'd1;
          end else begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
          end
        end
      end
      PUBLISH: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase

    if ((nxt_state == SETTLE) && (nxt_cnt >= STABLE_CNT)) begin
      cap       = 1'b1;
      nxt_state = HOLD;
    end

    if ((state != PUBLISH) && (&captured)) begin
      cap       = 1'b0;
      pub       = 1'b1;
      nxt_state = PUBLISH;
      nxt_cnt   = '0;
    end
  end

  // FSM state, digit slots and registered frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      invalid     <= '0;
      captured    <= '0;
      bcd_out     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        slot_bcd[i] <= '0;
      end
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      frame_valid <= pub;
      frame_err   <= pub & (|invalid);
      if (cap) begin
        slot_bcd[slot_idx] <= dec_bcd;
        invalid[slot_idx]  <= ~dec_valid;
        captured[slot_idx] <= 1'b1;
      end
      if (pub) begin
        bcd_out  <= {slot_bcd[3], slot_bcd[2], slot_bcd[1], slot_bcd[0]};
        captured <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Scoreboard bench for seg7_frame_decoder: the stimulus pushes each expected
// frame, a negedge monitor pops and compares on every frame_valid pulse.
module tb_seg7_frame_decoder;

  localparam logic [6:0] P0   = 7'b1111110;
  localparam logic [6:0] P1   = 7'b0110000;
  localparam logic [6:0] P2   = 7'b1101101;
  localparam logic [6:0] P3   = 7'b1111001;
  localparam logic [6:0] P4   = 7'b0110011;
  localparam logic [6:0] P5   = 7'b1011011;
  localparam logic [6:0] P6   = 7'b1011111;
  localparam logic [6:0] P7   = 7'b1110000;
  localparam logic [6:0] P8   = 7'b1111111;
  localparam logic [6:0] P9   = 7'b1111011;
  localparam logic [6:0] PBAD = 7'b1001001;
  localparam logic [6:0] PBLK = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_en = '0;
  logic [15:0] bcd_out;
  logic        frame_valid;
  logic        frame_err;

  typedef struct {
    logic [15:0] bcd;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          compared = 0;
  int          mismatched = 0;
  int          inv_viol = 0;
  logic [15:0] last_bcd = '0;
  logic        mon_en = 1'b0;

  seg7_frame_decoder #(.STABLE_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [15:0] bcd, input logic err);
    exp_t e;
    e.bcd = bcd;
    e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic scan(input logic [6:0] s, input int unsigned idx, input int unsigned n);
    seg_in = s;
    dig_en = 4'(4'b0001 << idx);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap(input int unsigned n);
    seg_in = '0;
    dig_en = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare published frames, and watch bcd_out/frame_err between frames.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (frame_valid) begin
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_frame: got bcd_out=%h err=%b, expected no frame", bcd_out, frame_err);
        end else begin
          mon_e = sb_q.pop_front();
          check("frame_bcd", bcd_out, mon_e.bcd);
          check("frame_err", {15'b0, frame_err}, {15'b0, mon_e.err});
          last_bcd = mon_e.bcd;
        end
      end else if ((frame_err !== 1'b0) || (bcd_out !== last_bcd)) begin
        inv_viol++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_valid", {15'b0, frame_valid}, 16'h0000);
    check("rst_err", {15'b0, frame_err}, 16'h0000);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    gap(2);

    // Basic frame 1,2,3,4 on digits 0..3
    expect_frame(16'h4321, 1'b0);
    scan(P1, 0, 4);
    scan(P2, 1, 4);
    scan(P3, 2, 4);
    scan(P4, 3, 4);
    gap(4);

    // Undecodable pattern on digit 2
    expect_frame(16'h7F65, 1'b1);
    scan(P5, 0, 4);
    scan(P6, 1, 4);
    scan(PBAD, 2, 4);
    scan(P7, 3, 4);
    gap(4);

    // Two enables set never capture; idle gaps between digits are harmless
    seg_in = P8;
    dig_en = 4'b0011;
    repeat (10) @(posedge clk);
    #1;
    gap(3);
    scan(P0, 2, 4);
    gap(3);
    scan(P2, 3, 4);
    gap(3);
    scan(P9, 0, 4);
    gap(3);
    expect_frame(16'h2089, 1'b0);
    scan(P8, 1, 4);
    gap(4);

    // Digit 1 toggling every cycle must not capture until it settles
    scan(P3, 0, 4);
    scan(P5, 2, 4);
    scan(P6, 3, 4);
    for (int i = 0; i < 8; i++) begin
      scan((i % 2 == 0) ? P8 : P0, 1, 1);
    end
    expect_frame(16'h6583, 1'b0);
    scan(P8, 1, 4);
    gap(4);

    // Reset after three captures: outputs clear at once, partial frame dropped
    scan(P7, 0, 4);
    scan(P7, 1, 4);
    scan(P7, 2, 4);
    gap(2);
    rst_n = 1'b0;
    #2;
    check("async_rst_bcd", bcd_out, 16'h0000);
    check("async_rst_valid", {15'b0, frame_valid}, 16'h0000);
    check("async_rst_err", {15'b0, frame_err}, 16'h0000);
    last_bcd = '0;
    #1;
    rst_n = 1'b1;
    gap(3);
    scan(P2, 1, 4);
    scan(P3, 2, 4);
    scan(P4, 3, 4);
    gap(4);
    expect_frame(16'h4329, 1'b0);
    scan(P9, 0, 4);
    gap(4);

    // Blank pattern on digit 3
`ifdef SEG7_BLANK_EN
    expect_frame(16'hA210, 1'b0);
`else
    expect_frame(16'hF210, 1'b1);
`endif
    scan(P0, 0, 4);
    scan(P1, 1, 4);
    scan(P2, 2, 4);
    scan(PBLK, 3, 4);
    gap(4);

    // Drain: every expected frame must have been seen
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL frames_missing: got %0d frames outstanding, expected 0", sb_q.size());
    end
    compared++;
    if (inv_viol != 0) begin
      mismatched++;
      $display("FAIL hold_between_frames: got %0d cycles with changed bcd_out or frame_err high, expected 0", inv_viol);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_frame_decoder.md
SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 2, meaning consecutive identical samples required before a digit is captured (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port seg_in  input  7  segment pattern, abcdefg order, bit6 = a, active-high.
REQ-005 SHALL have port dig_en  input  4  digit enables from the display scanner, active-high, bit n = digit n.
REQ-006 SHALL have port bcd_out  output  16  last published frame, bits [4n+3:4n] = digit n.
REQ-007 SHALL have port frame_valid  output  1  one-cycle pulse when bcd_out is updated.
REQ-008 SHALL have port frame_err  output  1  valid with frame_valid; high if any digit in that frame was undecodable.

Function
REQ-009 SHALL register seg_in and dig_en in one sample stage; all decisions use sampled values only.
REQ-010 SHALL decode patterns 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011 to BCD 0..9.
REQ-011 SHALL map any other pattern to 4'hF and mark that digit slot invalid.
REQ-012 SHALL implement FSM states IDLE, SETTLE, HOLD and PUBLISH.
REQ-013 IDLE: sampled dig_en one-hot -> SETTLE with the stability counter at 1; otherwise stay in IDLE.
REQ-014 SETTLE: each cycle in which sampled seg and dig_en equal the previous sample increments the counter.
REQ-015 SETTLE: a sample differing from the previous one restarts the counter at 1 if dig_en is still one-hot, else goes to IDLE.
REQ-016 SETTLE: when the counter reaches STABLE_CYCLES, SHALL write the decoded digit into the slot selected by dig_en, set that slot's captured flag and go to HOLD.
REQ-017 With STABLE_CYCLES = 1, capture SHALL occur on the first one-hot sample.
REQ-018 HOLD: no further capture while sampled dig_en is unchanged; a change to a different one-hot value -> SETTLE (counter 1); a change to a non-one-hot value -> IDLE.
REQ-019 A re-captured slot SHALL overwrite that slot's value and invalid flag.
REQ-020 When all four captured flags are set, SHALL go to PUBLISH on the next edge.
REQ-021 PUBLISH: SHALL load bcd_out from the four slots, pulse frame_valid for exactly one cycle, drive frame_err = OR of slot invalid flags, clear all captured flags, then go to IDLE.
REQ-022 frame_err SHALL be 0 whenever frame_valid is 0.
REQ-023 bcd_out SHALL hold its value between frames.
REQ-024 Latency SHALL be: 4th-digit capture edge + 1 cycle to frame_valid.
REQ-025 Sampled dig_en of 0000 or with two or more bits set SHALL never capture.

Reset
REQ-026 rst_n low SHALL immediately force: FSM = IDLE, counter = 0, captured and invalid flags = 0, sample registers = 0, bcd_out = 16'h0000, frame_valid = 0, frame_err = 0.
REQ-027 Reset asserted mid-frame SHALL discard all partial captures; the first frame after reset requires four fresh captures.

Configuration
REQ-028 Macro SEG7_BLANK_EN defined: pattern 0000000 SHALL decode to 4'hA (blank) as a valid digit.
REQ-029 Macro SEG7_BLANK_EN absent: pattern 0000000 SHALL be handled like any other undecodable pattern (4'hF, invalid).

Structure
REQ-030 Package seg7_pkg SHALL hold the ten segment constants, the FSM state enum, BCD_INVALID = 4'hF and BCD_BLANK = 4'hA.
REQ-031 Pattern decoding SHALL live in combinational sub-module seg7_decode (7-bit pattern in, 4-bit BCD plus valid out), instantiated once on the sampled pattern.

Verification
REQ-032 Scan digits 0..3 with patterns for 1,2,3,4, each held 4 cycles, STABLE_CYCLES=2 -> one frame_valid pulse, bcd_out=16'h4321, frame_err=0.
REQ-033 Digit 2 pattern 1001001 -> bcd_out[11:8]=4'hF, frame_err=1 on the frame_valid cycle.
REQ-034 Pattern toggling between 8 and 0 every cycle on digit 1 -> no capture for digit 1 and no frame_valid until the pattern holds for 2 cycles.
REQ-035 dig_en=0011 held 10 cycles -> no capture; dig_en=0000 between digits -> no effect on the frame.
REQ-036 rst_n pulsed low after 3 captures -> outputs zero asynchronously; the next frame requires all 4 digits.
REQ-037 Blank pattern 0000000 on digit 3 -> 4'hA with frame_err=0 when SEG7_BLANK_EN is defined; 4'hF with frame_err=1 when it is not.
